// File: rtl/button_conditioner.sv
// Synchroniser, debouncer and press/release pulse generator for the stopwatch buttons.
// Optional auto-repeat of btn_press while a button is held: define BTN_AUTOREPEAT_EN.
module button_conditioner #(
    parameter int NUM_BTN         = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW} state_t;

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
        $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
    end

    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    state_t             state      [NUM_BTN];
    state_t             state_next [NUM_BTN];
    logic [CNT_W-1:0]   cnt        [NUM_BTN];
    logic [CNT_W-1:0]   cnt_next   [NUM_BTN];
    logic [NUM_BTN-1:0] level_next;
    logic [NUM_BTN-1:0] press_next;
    logic [NUM_BTN-1:0] release_next;
    logic [NUM_BTN-1:0] rpt_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1       <= '0;
            sync2       <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                state[i] <= STABLE_LOW;
                cnt[i]   <= '0;
            end
        end else begin
            sync1       <= btn_raw;
            sync2       <= sync1;
            btn_level   <= level_next;
            btn_press   <= press_next;
            btn_release <= release_next;
            for (int i = 0; i < NUM_BTN; i++) begin
                state[i] <= state_next[i];
                cnt[i]   <= cnt_next[i];
            end
        end
    end

    // The counter restarts at 1 on the first differing sample and saturates at the accept point.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            state_next[i] = state[i];
            cnt_next[i]   = cnt[i];
            case (state[i])
                STABLE_LOW: begin
                    if (sync2[i]) begin
                        state_next[i] = WAIT_HIGH;
                        cnt_next[i]   = CNT_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (!sync2[i]) begin
                        state_next[i] = STABLE_LOW;
                        cnt_next[i]   = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_next[i] = STABLE_HIGH;
                        cnt_next[i]   = '0;
                    end else begin
                        cnt_next[i] = cnt[i] + 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (!sync2[i]) begin
                        state_next[i] = WAIT_LOW;
                        cnt_next[i]   = CNT_W'(1);
                    end
                end
                WAIT_LOW: begin
                    if (sync2[i]) begin
                        state_next[i] = STABLE_HIGH;
                        cnt_next[i]   = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_next[i] = STABLE_LOW;
                        cnt_next[i]   = '0;
                    end else begin
                        cnt_next[i] = cnt[i] + 1'b1;
                    end
                end
                default: begin
                    state_next[i] = STABLE_LOW;
                    cnt_next[i]   = '0;
                end
            endcase
        end
    end

    always_comb begin
        level_next   = btn_level;
        press_next   = '0;
        release_next = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (state[i] == WAIT_HIGH && sync2[i] && cnt[i] == CNT_LAST) begin
                level_next[i] = 1'b1;
                press_next[i] = 1'b1;
            end
            if (state[i] == WAIT_LOW && !sync2[i] && cnt[i] == CNT_LAST) begin
                level_next[i]   = 1'b0;
                release_next[i] = 1'b1;
            end
            // A repeat that coincides with the release accept is dropped.
            if (rpt_fire[i] && !release_next[i]) begin
                press_next[i] = 1'b1;
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0]   rpt_cnt [NUM_BTN];
    logic [NUM_BTN-1:0] rpt_first_done;

    always_comb begin
        rpt_fire = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (state[i] == STABLE_HIGH || state[i] == WAIT_LOW) begin
                rpt_fire[i] = rpt_first_done[i] ? (rpt_cnt[i] == RPT_PERIOD_LAST)
                                                : (rpt_cnt[i] == RPT_DELAY_LAST);
            end
        end
    end

    // Counting continues across WAIT_LOW bounces; only leaving level 1 clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_first_done <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                rpt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if ((state[i] == STABLE_HIGH || state[i] == WAIT_LOW) && !release_next[i]) begin
                    if (rpt_fire[i]) begin
                        rpt_cnt[i]        <= '0;
                        rpt_first_done[i] <= 1'b1;
                    end else begin
                        rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                    end
                end else begin
                    rpt_cnt[i]        <= '0;
                    rpt_first_done[i] <= 1'b0;
                end
            end
        end
    end
`else
    assign rpt_fire = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner with DEBOUNCE_CYCLES=8.
// Expected press timing also covers a BTN_AUTOREPEAT_EN build (delay 20, period 5).
module tb_button_conditioner;
    localparam int NUM_BTN    = 3;
    localparam int DEB        = 8;
    localparam int RPT_DELAY  = 20;
    localparam int RPT_PERIOD = 5;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .NUM_BTN        (NUM_BTN),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RPT_DELAY),
        .REPEAT_PERIOD  (RPT_PERIOD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NUM_BTN-1:0] raw, input logic rst);
        btn_raw = raw;
        reset   = rst;
    endtask

    // Cycle c (counted from the stimulus change) carries a press pulse when it is the first
    // accept at cycle 'first' or, with auto-repeat, a later repeat slot.
    function automatic bit pressDue(input int c, input int first);
        if (c == first) return 1'b1;
        if (AUTOREP && c >= first + RPT_DELAY && ((c - first - RPT_DELAY) % RPT_PERIOD) == 0)
            return 1'b1;
        return 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic [NUM_BTN-1:0] exp_level,
                               input logic [NUM_BTN-1:0] exp_press,
                               input logic [NUM_BTN-1:0] exp_release);
        compared++;
        assert (btn_level === exp_level) else begin
            mismatched++;
            $error("[TB] FAIL %s btn_level: observed %b expected %b", tag, btn_level, exp_level);
        end
        compared++;
        assert (btn_press === exp_press) else begin
            mismatched++;
            $error("[TB] FAIL %s btn_press: observed %b expected %b", tag, btn_press, exp_press);
        end
        compared++;
        assert (btn_release === exp_release) else begin
            mismatched++;
            $error("[TB] FAIL %s btn_release: observed %b expected %b", tag, btn_release, exp_release);
        end
    endtask

    initial begin
        // Reset held 3 cycles with every button pressed
        applyStimulus(3'b111, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            checkOutput($sformatf("reset_c%0d", c), 3'b000, 3'b000, 3'b000);
        end
        applyStimulus(3'b111, 1'b0);
        tick();
        checkOutput("post_reset", 3'b000, 3'b000, 3'b000);
        applyStimulus(3'b000, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            tick();
            checkOutput($sformatf("idle_c%0d", c), 3'b000, 3'b000, 3'b000);
        end

        // Clean press on channel 0: accept lands 10 cycles after the input change
        applyStimulus(3'b001, 1'b0);
        for (int c = 1; c <= 30; c++) begin
            tick();
            checkOutput($sformatf("press0_c%0d", c), (c >= 10) ? 3'b001 : 3'b000,
                        pressDue(c, 10) ? 3'b001 : 3'b000, 3'b000);
        end
        applyStimulus(3'b000, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            tick();
            checkOutput($sformatf("release0_c%0d", c), (c < 10) ? 3'b001 : 3'b000,
                        (pressDue(c + 30, 10) && c < 10) ? 3'b001 : 3'b000,
                        (c == 10) ? 3'b001 : 3'b000);
        end

        // Bounce on channel 1: high 5, low 2, high 6, then low
        for (int c = 1; c <= 27; c++) begin
            applyStimulus((c <= 5 || (c >= 8 && c <= 13)) ? 3'b010 : 3'b000, 1'b0);
            tick();
            checkOutput($sformatf("bounce1_c%0d", c), 3'b000, 3'b000, 3'b000);
        end

        // Channel 2 press then release
        applyStimulus(3'b100, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            tick();
            checkOutput($sformatf("press2_c%0d", c), (c >= 10) ? 3'b100 : 3'b000,
                        pressDue(c, 10) ? 3'b100 : 3'b000, 3'b000);
        end
        applyStimulus(3'b000, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            tick();
            checkOutput($sformatf("release2_c%0d", c), (c < 10) ? 3'b100 : 3'b000,
                        (pressDue(c + 12, 10) && c < 10) ? 3'b100 : 3'b000,
                        (c == 10) ? 3'b100 : 3'b000);
        end

        // Simultaneous press on channels 0 and 2
        applyStimulus(3'b101, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            tick();
            checkOutput($sformatf("simul_c%0d", c), (c >= 10) ? 3'b101 : 3'b000,
                        pressDue(c, 10) ? 3'b101 : 3'b000, 3'b000);
        end

        // One-cycle reset while held: no release, fresh press 10 cycles after reset drops
        applyStimulus(3'b101, 1'b1);
        tick();
        checkOutput("reset_mid", 3'b000, 3'b000, 3'b000);
        applyStimulus(3'b101, 1'b0);
        for (int c = 1; c <= 45; c++) begin
            tick();
            checkOutput($sformatf("rehold_c%0d", c), (c >= 10) ? 3'b101 : 3'b000,
                        pressDue(c, 10) ? 3'b101 : 3'b000, 3'b000);
        end

        // Final release of both held channels
        applyStimulus(3'b000, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            tick();
            checkOutput($sformatf("final_c%0d", c), (c < 10) ? 3'b101 : 3'b000,
                        (pressDue(c + 45, 10) && c < 10) ? 3'b101 : 3'b000,
                        (c == 10) ? 3'b101 : 3'b000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input stage that sits directly upstream of stopwatch_top's start/stop/pause inputs.
- Takes raw, asynchronous, bouncing push-button levels from board pins and synchronises them into clk.
- Debounces each button independently.
- Emits a stable level plus single-cycle press and release pulses. The stopwatch control FSM consumes the press pulses.

Parameters:
- NUM_BTN, 3: number of independent button channels. Bit 0 = start, 1 = stop, 2 = pause.
- DEBOUNCE_CYCLES, 500000: consecutive stable clk cycles required to accept a new level (10 ms at 50 MHz). Legal range ≥ 2.
- REPEAT_DELAY, 25000000: cycles from accepted press to first auto-repeat pulse. Used only with BTN_AUTOREPEAT_EN.
- REPEAT_PERIOD, 5000000: cycles between subsequent auto-repeat pulses. Used only with BTN_AUTOREPEAT_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- btn_raw  input  NUM_BTN  raw asynchronous button levels, 1 = pressed
- btn_level  output  NUM_BTN  debounced button level
- btn_press  output  NUM_BTN  1-cycle pulse on accepted 0→1 of btn_level (and on auto-repeat when enabled)
- btn_release  output  NUM_BTN  1-cycle pulse on accepted 1→0 of btn_level

Behaviour:
- One clock (clk). Reset is synchronous and active-high.
- Reset values: sync flops 0, all counters 0, every channel in state STABLE_LOW; btn_level, btn_press, btn_release all 0. All outputs are registered.
- Synchroniser: two flops per channel; s = second flop. No logic between the flops.
- Per-channel FSM, 4 states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
  - STABLE_LOW: if s=1 → WAIT_HIGH, cnt←1.
  - WAIT_HIGH:
    - if s=0 → STABLE_LOW, cnt←0.
    - else if cnt = DEBOUNCE_CYCLES−1 → STABLE_HIGH: btn_level←1, btn_press←1 for one cycle, cnt←0.
    - else cnt←cnt+1.
  - STABLE_HIGH / WAIT_LOW: mirror image of the above; the accept produces btn_level←0 and a btn_release pulse.
- Counter width: clog2(DEBOUNCE_CYCLES) bits. The counter never wraps; it saturates at the accept point.
- Latency: raw edge sampled at edge k, held → btn_level and the pulse are visible after edge k+1+DEBOUNCE_CYCLES. That is 2 sync stages plus DEBOUNCE_CYCLES−1 counts, measured from s.
- Any glitch shorter than DEBOUNCE_CYCLES cycles (as seen on s) produces no output change and no pulse.
- btn_press and btn_release are never asserted in the same cycle for the same channel. Each is at most 1 cycle wide; the next cycle is forced back to 0.
- Channels are fully independent. Simultaneous accepts on several channels produce pulses in the same cycle. No priority or masking.
- Reset mid-operation:
  - All state discards immediately.
  - A button still held after reset is re-debounced from STABLE_LOW, producing a fresh btn_press DEBOUNCE_CYCLES+2 cycles after reset deasserts.
  - No btn_release is generated by reset itself.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - Each channel has a repeat counter that starts at the accepted press while in STABLE_HIGH or WAIT_LOW (level still 1).
  - After REPEAT_DELAY cycles, btn_press pulses again; thereafter it pulses every REPEAT_PERIOD cycles.
  - The repeat counter clears on leaving level 1 or on reset.
  - A bounce that returns WAIT_LOW→STABLE_HIGH does not reset the repeat counter.
- Undefined: no repeat logic is synthesised; btn_press fires exactly once per accepted press.

Test Plan:
- Reset: assert reset 3 cycles with btn_raw=3'b111 → btn_level=0, btn_press=0 and btn_release=0 during reset and on the first cycle after.
- Clean press (DEBOUNCE_CYCLES=8): btn_raw[0] 0→1 sampled at edge k and held 30 cycles → btn_press[0]=1 only in the cycle after edge k+9; btn_level[0]=1 from then on; other bits stay 0.
- Bounce rejection (DEBOUNCE_CYCLES=8): btn_raw[1] pulses high 5 cycles, low 2, high 6, then low → no btn_press[1], btn_level[1] stays 0 throughout.
- Release: from btn_level[2]=1, drop btn_raw[2] for 20 cycles → exactly one btn_release[2] pulse 9 cycles after the sampled falling edge; btn_level[2]=0 afterwards.
- Simultaneous: btn_raw 3'b000→3'b101 in one cycle, held → btn_press=3'b101 in a single common cycle.
- Reset mid-hold: btn_level[0]=1 with button held, reset pulsed 1 cycle → btn_level[0]=0 with no release pulse, then btn_press[0] 10 cycles after reset drops. With BTN_AUTOREPEAT_EN and REPEAT_DELAY=20, REPEAT_PERIOD=5, holding the button yields further pulses at +20, +25 and +30 cycles after the first press.
